// File: rtl/fft_pingpong_buffer.sv
`default_nettype none
// =============================================================================
// fft_pingpong_buffer : two-bank complex-sample buffer between the front end and
// an in-place FFT core. Optional macro FFT_PINGPONG_BITREV_EN. Rev 1.0
// =============================================================================
module fft_pingpong_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_re,
    input  logic [DATA_W-1:0]   in_im,
    output logic                fft_start,
    input  logic                fft_done,
    output logic                fft_busy,
    input  logic [ADDR_W-1:0]   fft_ad,
    input  logic                fft_we,
    input  logic [2*DATA_W-1:0] fft_din,
    output logic [2*DATA_W-1:0] fft_dout,
    output logic                fill_bank,
    output logic                overrun
);
    localparam int WORD_W = 2 * DATA_W;
    localparam int N      = 1 << ADDR_W;

    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    logic [1:0][1:0]    status_q, status_d;
    logic               wr_sel_q, wr_sel_d;
    logic               fft_sel_q, fft_sel_d;
    logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic               fft_start_q, fft_start_d;
    logic               fft_busy_q, fft_busy_d;
    logic               overrun_q, overrun_d;
    logic [WORD_W-1:0]  fft_dout_q, fft_dout_d;

    logic               wr_fire;
    logic               fft_wr;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WORD_W-1:0]  wr_word;
    logic [WORD_W-1:0]  bank_rd [2];

    assign in_ready  = (status_q[wr_sel_q] == ST_FREE) || (status_q[wr_sel_q] == ST_FILL);
    assign wr_fire   = in_valid && in_ready;
    assign fft_wr    = fft_busy_q && fft_we;
    assign wr_word   = {in_re, in_im};

`ifdef FFT_PINGPONG_BITREV_EN
    // Bit-reversed fill order so a DIT in-place FFT sees its natural input layout.
    for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
        assign wr_addr[i] = wr_cnt_q[ADDR_W-1-i];
    end
`else
    assign wr_addr = wr_cnt_q;
`endif

    // The writer and the FFT never own the same bank, so one write port per bank suffices.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [WORD_W-1:0] mem [N];

        always_ff @(posedge clk) begin
            if (wr_fire && (wr_sel_q == 1'(b))) begin
                mem[wr_addr] <= wr_word;
            end else if (fft_wr && (fft_sel_q == 1'(b))) begin
                mem[fft_ad] <= fft_din;
            end
        end

        assign bank_rd[b] = mem[fft_ad];
    end

    always_comb begin
        status_d    = status_q;
        wr_sel_d    = wr_sel_q;
        fft_sel_d   = fft_sel_q;
        wr_cnt_d    = wr_cnt_q;
        fft_start_d = 1'b0;
        fft_busy_d  = fft_busy_q;
        overrun_d   = overrun_q | (in_valid & ~in_ready);
        fft_dout_d  = fft_busy_q ? bank_rd[fft_sel_q] : fft_dout_q;

        // Handoff reads the registered status, giving one cycle from last write to start.
        if (fft_busy_q) begin
            if (fft_done) begin
                status_d[fft_sel_q] = ST_FREE;
                fft_sel_d           = ~fft_sel_q;
                fft_busy_d          = 1'b0;
            end
        end else if (status_q[fft_sel_q] == ST_READY) begin
            status_d[fft_sel_q] = ST_BUSY;
            fft_start_d         = 1'b1;
            fft_busy_d          = 1'b1;
        end

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (wr_cnt_q == CNT_LAST) begin
                status_d[wr_sel_q] = ST_READY;
                wr_sel_d           = ~wr_sel_q;
            end else begin
                status_d[wr_sel_q] = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q    <= {ST_FREE, ST_FREE};
            wr_sel_q    <= 1'b0;
            fft_sel_q   <= 1'b0;
            wr_cnt_q    <= '0;
            fft_start_q <= 1'b0;
            fft_busy_q  <= 1'b0;
            overrun_q   <= 1'b0;
            fft_dout_q  <= '0;
        end else begin
            status_q    <= status_d;
            wr_sel_q    <= wr_sel_d;
            fft_sel_q   <= fft_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            fft_start_q <= fft_start_d;
            fft_busy_q  <= fft_busy_d;
            overrun_q   <= overrun_d;
            fft_dout_q  <= fft_dout_d;
        end
    end

    assign fft_start = fft_start_q;
    assign fft_busy  = fft_busy_q;
    assign fft_dout  = fft_dout_q;
    assign fill_bank = wr_sel_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_pingpong_buffer.sv
`default_nettype none
// =============================================================================
// tb_fft_pingpong_buffer : directed + randomized bench with a bank-occupancy
// reference model. Rev 1.0
// =============================================================================
module tb_fft_pingpong_buffer;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 1 << AW;
    localparam int WW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          fft_start;
    logic          fft_done = 1'b0;
    logic          fft_busy;
    logic [AW-1:0] fft_ad = '0;
    logic          fft_we = 1'b0;
    logic [WW-1:0] fft_din = '0;
    logic [WW-1:0] fft_dout;
    logic          fill_bank;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: samples held per bank, who owns the FFT, and bank contents.
    int            m_cnt [2];
    int            m_wr;
    int            m_fsel;
    bit            m_owned;
    bit            m_start;
    bit            m_over;
    logic [WW-1:0] m_dout;
    logic [WW-1:0] m_mem [2][N];
    logic [WW-1:0] first_word;

    fft_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .fft_busy  (fft_busy),
        .fft_ad    (fft_ad),
        .fft_we    (fft_we),
        .fft_din   (fft_din),
        .fft_dout  (fft_dout),
        .fill_bank (fill_bank),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic int waddr(input int k);
        int r;
        r = k;
`ifdef FFT_PINGPONG_BITREV_EN
        r = 0;
        for (int i = 0; i < AW; i++) begin
            if (k[i]) r = r | (1 << (AW - 1 - i));
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_cnt[m_wr] < N});
        chk("fft_start", {31'd0, fft_start}, {31'd0, m_start});
        chk("fft_busy",  {31'd0, fft_busy},  {31'd0, m_owned});
        chk("fill_bank", {31'd0, fill_bank}, 32'(m_wr));
        chk("overrun",   {31'd0, overrun},   {31'd0, m_over});
        chk("fft_dout",  fft_dout,           m_dout);
    endtask

    // Advance the model on the inputs present before the edge, then compare.
    task automatic model_step();
        bit rdy;
        bit nstart;
        rdy    = m_cnt[m_wr] < N;
        nstart = 1'b0;
        if (in_valid && !rdy) m_over = 1'b1;
        if (m_owned) begin
            m_dout = m_mem[m_fsel][fft_ad];
            if (fft_we) m_mem[m_fsel][fft_ad] = fft_din;
            if (fft_done) begin
                m_cnt[m_fsel] = 0;
                m_owned       = 1'b0;
                m_fsel        = 1 - m_fsel;
            end
        end else if (m_cnt[m_fsel] == N) begin
            nstart  = 1'b1;
            m_owned = 1'b1;
        end
        if (in_valid && rdy) begin
            m_mem[m_wr][waddr(m_cnt[m_wr])] = {in_re, in_im};
            m_cnt[m_wr]++;
            if (m_cnt[m_wr] == N) m_wr = 1 - m_wr;
        end
        m_start = nstart;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        fft_done = 1'b0;
        fft_we   = 1'b0;
        rst_n    = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_wr     = 0;
        m_fsel   = 0;
        m_owned  = 1'b0;
        m_start  = 1'b0;
        m_over   = 1'b0;
        m_dout   = '0;
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        cycle();
    endtask

    initial begin
        #2;
        do_reset();

        // Ramp stream re=k, im=-k into bank 0
        for (int k = 0; k < N; k++) send(DW'(k), DW'(-k));
        in_valid = 1'b0;
        chk("start_not_yet", {31'd0, fft_start}, 32'd0);
        cycle();
        chk("start_pulse", {31'd0, fft_start}, 32'd1);
        chk("fill_bank_1", {31'd0, fill_bank}, 32'd1);
        fft_ad = 3'd5;
        cycle();
        chk("read_ad5", fft_dout, 32'h0005_FFFB);
        chk("start_one_cycle", {31'd0, fft_start}, 32'd0);
        fft_ad = 3'd4;
        cycle();
`ifdef FFT_PINGPONG_BITREV_EN
        chk("read_ad4", fft_dout, 32'h0001_FFFF);
`else
        chk("read_ad4", fft_dout, 32'h0004_FFFC);
`endif

        // FFT write then read back, and read-before-write on the same address
        fft_ad  = 3'd3;
        fft_we  = 1'b1;
        fft_din = 32'hDEAD_BEEF;
        cycle();
`ifdef FFT_PINGPONG_BITREV_EN
        chk("rbw_old", fft_dout, 32'h0006_FFFA);
`else
        chk("rbw_old", fft_dout, 32'h0003_FFFD);
`endif
        fft_we = 1'b0;
        cycle();
        chk("read_back", fft_dout, 32'hDEAD_BEEF);

        // Fill bank 1 while the FFT randomly accesses bank 0
        for (int k = 0; k < N; k++) begin
            fft_ad  = AW'($urandom_range(0, N - 1));
            fft_we  = 1'($urandom_range(0, 1));
            fft_din = $urandom;
            send(DW'($urandom), DW'($urandom));
        end
        fft_we = 1'b0;
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        cycle();
        chk("overrun_set", {31'd0, overrun}, 32'd1);

        // Release while the writer is stalled
        fft_done = 1'b1;
        cycle();
        fft_done = 1'b0;
        in_valid = 1'b0;
        chk("ready_after_done", {31'd0, in_ready}, 32'd1);
        chk("busy_fell", {31'd0, fft_busy}, 32'd0);
        cycle();
        chk("start_bank1", {31'd0, fft_start}, 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_re    = DW'($urandom);
            in_im    = DW'($urandom);
            fft_ad   = AW'($urandom_range(0, N - 1));
            fft_we   = 1'($urandom_range(0, 1));
            fft_din  = $urandom;
            fft_done = ($urandom_range(0, 19) == 0);
            cycle();
        end
        in_valid = 1'b0;
        fft_we   = 1'b0;
        fft_done = 1'b0;
        cycle();

        // Reset in the middle of a fill, then a fresh stream
        do_reset();
        for (int k = 0; k < 5; k++) send(DW'($urandom), DW'($urandom));
        in_valid = 1'b0;
        #2;
        do_reset();
        chk("rst_fill_bank", {31'd0, fill_bank}, 32'd0);
        for (int k = 0; k < N; k++) begin
            send(DW'($urandom), DW'($urandom));
            if (k == 0) first_word = {in_re, in_im};
        end
        in_valid = 1'b0;
        fft_ad   = '0;
        cycle();
        chk("fresh_start", {31'd0, fft_start}, 32'd1);
        chk("fresh_fill_bank", {31'd0, fill_bank}, 32'd1);
        cycle();
        chk("fresh_word0", fft_dout, first_word);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
